// File: rtl/spi_flash_master.sv
// Wishbone-controlled SPI master for serial flash: DATA/CTRL/DIVIDER/SS registers,
// one transfer of 1..32 bits per GO, programmable clock divider and sampling edges.
module spi_flash_master #(
  parameter int          SS_NB     = 8,
  parameter logic [15:0] DIV_RESET = 16'h0000
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [4:2]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  input  logic             wb_we_i,
  input  logic             wb_stb_i,
  input  logic             wb_cyc_i,
  output logic             wb_ack_o,
  output logic             int_o,
  output logic             sclk_o,
  output logic             mosi_o,
  input  logic             miso_i,
  output logic [SS_NB-1:0] ss_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  localparam logic [2:0] ADR_DATA = 3'd0;
  localparam logic [2:0] ADR_CTRL = 3'd4;
  localparam logic [2:0] ADR_DIV  = 3'd5;
  localparam logic [2:0] ADR_SS   = 3'd6;

  logic [0:0]       state;
  logic [5:0]       char_len;
  logic             rx_neg, tx_neg, lsb, ie, ass;
  logic [15:0]      divider, cnt;
  logic [SS_NB-1:0] ss;
  logic [31:0]      tx, rx;
  logic [6:0]       edge_cnt;

  // Handshake: an access is accepted on the edge where stb&cyc is high and ack
  // is low; that edge performs the write, captures read data and raises ack.
  logic        access, wr, busy, start, tick, rising, last;
  logic        drive_tx, sample_rx;
  logic [5:0]  len, half, tx_k;
  logic [4:0]  tx_pos, rx_pos, start_pos;
  logic [31:0] rd_data;

  function automatic logic [5:0] eff_len(input logic [5:0] cl);
    return (cl == 6'd0 || cl > 6'd32) ? 6'd32 : cl;
  endfunction

  function automatic logic [4:0] bit_pos(input logic [5:0] k, input logic [5:0] l,
                                         input logic lsb_first);
    logic [5:0] p;
    p = lsb_first ? k : l - 6'd1 - k;
    return p[4:0];
  endfunction

  always_comb begin
    access    = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    wr        = access & wb_we_i;
    busy      = (state == XFER);
    start     = wr && (wb_adr_i == ADR_CTRL) && !busy && wb_dat_i[8];
    len       = eff_len(char_len);
    tick      = busy && (cnt == 16'd0);
    rising    = ~sclk_o;
    last      = tick && (edge_cnt == {len, 1'b0} - 7'd1);
    half      = edge_cnt[6:1];
    // With TX_NEG the falling edge of bit k-1 launches bit k; the last falling edge launches nothing.
    tx_k      = tx_neg ? half + 6'd1 : half;
    drive_tx  = tick && (tx_neg ? ~rising : rising) && (tx_k < len);
    sample_rx = tick && (rx_neg ? ~rising : rising);
    tx_pos    = bit_pos(tx_k, len, lsb);
    rx_pos    = bit_pos(half, len, lsb);
    start_pos = bit_pos(6'd0, eff_len(wb_dat_i[5:0]), wb_dat_i[11]);
  end

  always_comb begin
    rd_data = 32'd0;
    case (wb_adr_i)
      ADR_DATA: rd_data = rx;
      ADR_CTRL: rd_data = {18'd0, ass, ie, lsb, tx_neg, rx_neg, busy, 2'b00, char_len};
      ADR_DIV:  rd_data = {16'd0, divider};
      ADR_SS:   rd_data = {{(32-SS_NB){1'b0}}, ss};
      default:  rd_data = 32'd0;
    endcase
  end

  assign ss_o = (ass && !busy) ? {SS_NB{1'b1}} : ~ss;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state    <= IDLE;
      char_len <= 6'd0;
      rx_neg   <= 1'b0;
      tx_neg   <= 1'b0;
      lsb      <= 1'b0;
      ie       <= 1'b0;
      ass      <= 1'b0;
      divider  <= DIV_RESET;
      cnt      <= 16'd0;
      ss       <= '0;
      tx       <= 32'd0;
      rx       <= 32'd0;
      edge_cnt <= 7'd0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'd0;
      int_o    <= 1'b0;
      sclk_o   <= 1'b0;
      mosi_o   <= 1'b0;
    end else begin
      wb_ack_o <= access;
      if (access) wb_dat_o <= rd_data;
      if (wr && wb_adr_i == ADR_SS) ss <= wb_dat_i[SS_NB-1:0];

      if (!busy) begin
        if (wr && wb_adr_i == ADR_DATA) tx <= wb_dat_i;
        if (wr && wb_adr_i == ADR_DIV)  divider <= wb_dat_i[15:0];
        if (wr && wb_adr_i == ADR_CTRL) begin
          char_len <= wb_dat_i[5:0];
          rx_neg   <= wb_dat_i[9];
          tx_neg   <= wb_dat_i[10];
          lsb      <= wb_dat_i[11];
          ie       <= wb_dat_i[12];
          ass      <= wb_dat_i[13];
        end
        if (start) begin
          state    <= XFER;
          rx       <= 32'd0;
          cnt      <= divider;
          edge_cnt <= 7'd0;
          sclk_o   <= 1'b0;
          if (wb_dat_i[10]) mosi_o <= tx[start_pos];
        end
      end else if (tick) begin
        cnt      <= divider;
        edge_cnt <= edge_cnt + 7'd1;
        sclk_o   <= ~sclk_o;
        if (drive_tx)  mosi_o     <= tx[tx_pos];
        if (sample_rx) rx[rx_pos] <= miso_i;
        if (last) begin
          state  <= IDLE;
          sclk_o <= 1'b0;
        end
      end else begin
        cnt <= cnt - 16'd1;
      end

      // A completion outranks the clear caused by a simultaneous access.
      if (last && ie)  int_o <= 1'b1;
      else if (access) int_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_flash_master.sv
// Randomized bench for spi_flash_master: Wishbone driver tasks, read-data and MOSI
// scoreboards fed from a bit-level transfer model, timing checks and a final report.
module tb_spi_flash_master;

  localparam int          SS_NB   = 8;
  localparam logic [15:0] DIV_RST = 16'h0005;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [4:2]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i, wb_stb_i, wb_cyc_i;
  logic        wb_ack_o, int_o, sclk_o, mosi_o, miso_i;
  logic [SS_NB-1:0] ss_o;

  spi_flash_master #(.SS_NB(SS_NB), .DIV_RESET(DIV_RST)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_ack_o(wb_ack_o), .int_o(int_o), .sclk_o(sclk_o), .mosi_o(mosi_o),
    .miso_i(miso_i), .ss_o(ss_o)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 wb_clk = ~wb_clk;

  int cyc_n = 0;
  always @(posedge wb_clk) cyc_n <= cyc_n + 1;

  int miso_mode = 2;  // 0: loop mosi back, 1: tied high, 2: tied low
  always_comb miso_i = (miso_mode == 0) ? mosi_o : (miso_mode == 1);

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic        chk_q[$];
  string       name_q[$];
  logic        bit_q[$];

  int n_checks = 0, n_fail = 0, n_acc = 0, n_ack = 0;
  int exp_period = 2, sclk_rises = 0, last_rise = 0;
  int acc_edge = 0;
  logic sclk_prev = 1'b0, ack_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // ---------------- monitor: acks, read data, SCLK, MOSI ----------------
  always @(negedge wb_clk) begin
    logic [31:0] e;
    logic        c, b;
    string       nm;
    if (wb_ack_o) begin
      n_ack++;
      check("ack_pulse", {31'd0, ack_prev}, 32'd0);
      if (exp_q.size() == 0) check("ack_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front(); c = chk_q.pop_front(); nm = name_q.pop_front();
        if (c) check(nm, wb_dat_o, e);
      end
    end
    ack_prev = wb_ack_o;
    if (sclk_o && !sclk_prev) begin
      if (sclk_rises > 0) check("sclk_period", cyc_n - last_rise, exp_period);
      last_rise = cyc_n;
      sclk_rises++;
      if (bit_q.size() == 0) check("mosi_extra", 32'd1, 32'd0);
      else begin
        b = bit_q.pop_front();
        check("mosi_bit", {31'd0, mosi_o}, {31'd0, b});
      end
    end
    sclk_prev = sclk_o;
  end

  // ---------------- driver tasks (start and end on a negedge) ----------------
  task automatic wb_access(input logic [2:0] adr, input logic we, input logic [31:0] data,
                           input logic [31:0] exp, input logic chk, input string name);
    logic got;
    exp_q.push_back(exp); chk_q.push_back(chk); name_q.push_back(name);
    n_acc++;
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = data; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge wb_clk); #1;
      if (wb_ack_o) got = 1'b1;
    end
    acc_edge = cyc_n;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    @(negedge wb_clk);
  endtask

  task automatic wb_write(input logic [2:0] adr, input logic [31:0] data);
    wb_access(adr, 1'b1, data, 32'd0, 1'b0, "write");
  endtask

  task automatic wb_read(input logic [2:0] adr, input logic [31:0] exp, input string name);
    wb_access(adr, 1'b0, 32'd0, exp, 1'b1, name);
  endtask

  // Next access lands on posedge number n.
  task automatic wait_until(input int n);
    while (cyc_n < n - 1) @(negedge wb_clk);
  endtask

  // ---------------- reference model + one transfer ----------------
  task automatic run_xfer(input int div, input logic [5:0] cl, input logic lsb_f,
                          input logic txn, input logic rxn, input logic ie_f,
                          input logic ass_f, input logic [31:0] data,
                          input logic [7:0] ss_val, input int mode, input logic poke);
    int L, dur, start;
    logic [31:0] mask, exp_rx, ctrl_word;
    logic [7:0]  ss_cur, ss_exp;
    L = (cl == 0 || cl > 32) ? 32 : int'(cl);
    mask = (L == 32) ? 32'hFFFF_FFFF : ((32'h1 << L) - 32'h1);
    exp_rx = (mode == 0) ? (data & mask) : (mode == 1) ? mask : 32'd0;
    dur = 2 * L * (div + 1);
    ctrl_word = {18'd0, ass_f, ie_f, lsb_f, txn, rxn, 1'b1, 2'b00, cl};
    for (int k = 0; k < L; k++) bit_q.push_back(data[lsb_f ? k : L - 1 - k]);

    wb_write(3'd5, div);
    wb_write(3'd6, {24'd0, ss_val});
    wb_write(3'd0, data);
    miso_mode = mode;
    exp_period = 2 * (div + 1);
    sclk_rises = 0;
    wb_write(3'd4, ctrl_word);
    start = acc_edge;
    ss_cur = ss_val;
    ss_exp = ~ss_cur;
    check("ss_active", {24'd0, ss_o}, {24'd0, ss_exp});

    if (poke) begin
      wb_write(3'd4, 32'h0000_0105);
      wb_write(3'd0, ~data);
      ss_cur = ss_val ^ 8'h0F;
      wb_write(3'd6, {24'd0, ss_cur});
      ss_exp = ~ss_cur;
      check("ss_live_write", {24'd0, ss_o}, {24'd0, ss_exp});
    end

    wait_until(start + dur - 1);
    wb_read(3'd4, ctrl_word, "ctrl_busy");
    check("int_early", {31'd0, int_o}, 32'd0);
    @(negedge wb_clk);
    check("int_done", {31'd0, int_o}, {31'd0, ie_f});
    check("sclk_idle", {31'd0, sclk_o}, 32'd0);
    check("sclk_rises", sclk_rises, L);
    ss_exp = ass_f ? 8'hFF : ~ss_cur;
    check("ss_after", {24'd0, ss_o}, {24'd0, ss_exp});
    if (ie_f) begin
      repeat (2) @(negedge wb_clk);
      check("int_hold", {31'd0, int_o}, 32'd1);
    end
    wb_read(3'd4, ctrl_word & ~32'h0000_0100, "ctrl_done");
    check("int_cleared", {31'd0, int_o}, 32'd0);
    wb_read(3'd0, exp_rx, "rx_data");
    check("mosi_bits_left", bit_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int start, int_seen;
    logic [5:0] cl;
    logic txn, rxn;
    wb_rst = 1'b1;
    wb_adr_i = 3'd0; wb_dat_i = 32'd0; wb_we_i = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    repeat (3) @(negedge wb_clk);
    check("rst_ss_o", {24'd0, ss_o}, 32'h0000_00FF);
    check("rst_sclk", {31'd0, sclk_o}, 32'd0);
    check("rst_mosi", {31'd0, mosi_o}, 32'd0);
    check("rst_int", {31'd0, int_o}, 32'd0);
    check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("rst_dat_o", wb_dat_o, 32'd0);
    wb_rst = 1'b0;
    @(negedge wb_clk);

    wb_read(3'd4, 32'd0, "rst_ctrl");
    wb_read(3'd5, {16'd0, DIV_RST}, "rst_divider");
    wb_read(3'd6, 32'd0, "rst_ss");
    wb_read(3'd0, 32'd0, "rst_data");
    wb_write(3'd7, 32'hFFFF_FFFF);
    wb_read(3'd7, 32'd0, "unmapped");

    run_xfer(0, 6'd32, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hA5C3_0F01, 8'h01, 0, 1'b0);
    run_xfer(3, 6'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0081, 8'h01, 1, 1'b1);

    for (int t = 0; t < 10; t++) begin
      cl  = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(2, 63));
      txn = 1'($urandom_range(0, 1));
      rxn = 1'($urandom_range(0, 1));
      run_xfer($urandom_range(0, 3), cl, 1'($urandom_range(0, 1)), txn, rxn,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
               8'($urandom_range(1, 255)), (txn != rxn) ? 0 : $urandom_range(1, 2), 1'b0);
    end

    // Abort a 32-bit transfer with reset after 10 SCLK edges.
    wb_write(3'd5, 32'd0);
    wb_write(3'd6, 32'h0000_0003);
    wb_write(3'd0, 32'hFFFF_FFFF);
    miso_mode = 0; exp_period = 2; sclk_rises = 0;
    for (int k = 0; k < 32; k++) bit_q.push_back(1'b1);
    wb_write(3'd4, 32'h0000_3520);
    start = acc_edge;
    while (cyc_n < start + 10) @(negedge wb_clk);
    check("abort_mosi_pre", {31'd0, mosi_o}, 32'd1);
    check("abort_ss_pre", {24'd0, ss_o}, 32'h0000_00FC);
    #1 wb_rst = 1'b1;
    #1;
    check("abort_sclk", {31'd0, sclk_o}, 32'd0);
    check("abort_mosi", {31'd0, mosi_o}, 32'd0);
    check("abort_ss_o", {24'd0, ss_o}, 32'h0000_00FF);
    check("abort_int", {31'd0, int_o}, 32'd0);
    check("abort_ack", {31'd0, wb_ack_o}, 32'd0);
    check("abort_dat_o", wb_dat_o, 32'd0);
    bit_q.delete();
    int_seen = 0;
    repeat (3) begin
      @(negedge wb_clk);
      if (int_o) int_seen++;
    end
    wb_rst = 1'b0;
    repeat (80) begin
      @(negedge wb_clk);
      if (int_o) int_seen++;
    end
    check("abort_no_int", int_seen, 0);
    wb_read(3'd4, 32'd0, "abort_ctrl");
    wb_read(3'd5, {16'd0, DIV_RST}, "abort_divider");
    wb_read(3'd0, 32'd0, "abort_data");

    repeat (3) @(negedge wb_clk);
    check("ack_count", n_ack, n_acc);
    check("reads_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_flash_master.md
SPI_FLASH_MASTER -- requirements
Module: spi_flash_master

Interface
REQ-001 Parameter SS_NB, default 8: number of slave-select lines, range 1..8.
REQ-002 Parameter DIV_RESET, default 16'h0000: reset value of the DIVIDER register.
REQ-003 wb_clk  input  1  Wishbone and core clock.
REQ-004 wb_rst  input  1  reset, asynchronous, active-high.
REQ-005 wb_adr_i  input  [4:2]  word address: 0=DATA, 4=CTRL, 5=DIVIDER, 6=SS; other addresses read 0 and ignore writes.
REQ-006 wb_dat_i  input  32  write data; full-word writes only.
REQ-007 wb_dat_o  output  32  registered read data.
REQ-008 wb_we_i  input  1  write enable.
REQ-009 wb_stb_i, wb_cyc_i  input  1 each  strobe and cycle.
REQ-010 wb_ack_o  output  1  registered acknowledge.
REQ-011 int_o  output  1  transfer-complete interrupt, active-high.
REQ-012 sclk_o  output  1  SPI clock, idle low.
REQ-013 mosi_o  output  1  SPI serial data out.
REQ-014 miso_i  input  1  SPI serial data in.
REQ-015 ss_o  output  [SS_NB-1:0]  slave selects, active-low.

Function
REQ-016 wb_ack_o SHALL be 1 in the cycle after wb_stb_i&wb_cyc_i is high with wb_ack_o low, and SHALL be a single-cycle pulse per access.
REQ-017 Register writes and the read-data update SHALL take effect on the clock edge that raises wb_ack_o.
REQ-018 CTRL fields: [5:0] CHAR_LEN, [8] GO, [9] RX_NEG, [10] TX_NEG, [11] LSB, [12] IE, [13] ASS; other bits read 0.
REQ-019 CHAR_LEN 0 SHALL mean 32 bits; values 33..63 SHALL be treated as 32.
REQ-020 DIVIDER [15:0]: sclk_o toggles every DIVIDER+1 wb_clk cycles, so the SCLK period is 2*(DIVIDER+1) cycles.
REQ-021 SS [SS_NB-1:0]: with ASS=0, ss_o = ~SS; with ASS=1, ss_o = ~SS only while GO=1 and all-ones otherwise.
REQ-022 States SHALL be IDLE and XFER; writing CTRL with GO=1 in IDLE latches the CTRL fields, clears the RX shift register, and enters XFER.
REQ-023 In XFER the first SCLK edge (rising) SHALL occur DIVIDER+1 cycles after GO is set, and subsequent edges every DIVIDER+1 cycles, for 2*len edges in total.
REQ-024 TX order: LSB=0 shifts MSB-first from bit len-1 down to bit 0; LSB=1 shifts from bit 0 up to bit len-1.
REQ-025 TX_NEG=1: the first bit SHALL be driven on the cycle XFER is entered, with later bits driven on falling edges; TX_NEG=0: each bit SHALL be driven on a rising edge.
REQ-026 RX_NEG=0 SHALL sample miso_i on rising edges; RX_NEG=1 SHALL sample on falling edges.
REQ-027 RX bits SHALL land at the same bit positions the corresponding TX bits were taken from; bits [31:len] SHALL read 0.
REQ-028 On the final (2*len-th) edge: sclk_o low, GO cleared, state returns to IDLE, and int_o set if IE=1, all in the same cycle; total GO-high time = 2*len*(DIVIDER+1) cycles.
REQ-029 A DATA read SHALL return the RX register; a DATA write SHALL load the TX register.
REQ-030 While GO=1, writes to DATA, CTRL and DIVIDER SHALL be ignored but still acknowledged; SS writes SHALL take effect immediately.
REQ-031 A CTRL read SHALL return the stored fields with the live GO bit.
REQ-032 int_o SHALL clear on any acknowledged access; a completion in the same cycle as an access takes priority and sets int_o.
REQ-033 mosi_o SHALL hold its last value in IDLE.

Reset
REQ-034 wb_rst SHALL immediately force: CTRL=0, DATA TX/RX=0, DIVIDER=DIV_RESET, SS=0, state IDLE, wb_ack_o=0, wb_dat_o=0, int_o=0, sclk_o=0, mosi_o=0, ss_o=all ones.
REQ-035 Reset asserted mid-transfer SHALL abort the transfer with no completion interrupt.

Verification
REQ-036 Reset, then read CTRL, DIVIDER and SS -> 0, DIV_RESET, 0; ss_o=8'hFF; a single access produces exactly one ack pulse.
REQ-037 DIVIDER=0, SS=1, DATA=32'hA5C3_0F01, CTRL=0x0520 (len 32, TX_NEG, GO), with miso_i looped to mosi_o -> GO reads 0 after 64 cycles, DATA reads 32'hA5C3_0F01, ss_o=8'hFE throughout.
REQ-038 DIVIDER=3, CTRL len=8, LSB=1, IE=1, ASS=1, DATA=8'h81, miso_i tied 1 -> SCLK period 8 cycles, transfer 64 cycles; DATA reads 32'h0000_00FF; int_o=1 until the next access; ss_o is low only during the transfer.
REQ-039 Write CTRL and DATA while busy -> both acknowledged; the in-flight transfer length and data are unchanged.
REQ-040 Assert wb_rst after 10 edges of a 32-bit transfer -> all outputs take their reset values immediately and no int_o pulse occurs.
